circuito_programavel: RTL and testbench

CIRCUITO_PROGRAMAVEL -- requirements
Module: circuito_programavel

---
 rtl/circuito_programavel.sv | 131 +++++++++++++
 tb/tb_circuito_programavel.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/circuito_programavel.sv
// Programmable boolean function: a 2**N_IN-entry truth table, reloadable bit-serially.
// Optional hit counter enabled by defining CIRCUITO_CNT_EN.
module circuito_programavel #(
    parameter int unsigned             N_IN       = 4,
    parameter logic [(2**N_IN)-1:0]    TABLE_INIT = 16'h030B,
    parameter int unsigned             CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             in_valid,
    output logic             x,
    output logic             x_valid,
    input  logic             start_load,
    input  logic             load_bit,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    input  logic             clr_cnt
);

    localparam int unsigned TBL_W = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TBL_W - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [TBL_W-1:0] active_q, active_d;
    logic [TBL_W-1:0] shadow_q, shadow_d;
    logic [TBL_W-1:0] shadow_upd;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;

    // Load sequencing; the final bit is merged into the table in the same edge as the commit.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        shadow_upd = shadow_q;
        shadow_upd[idx_q] = load_bit;
        case (state_q)
            ST_RUN: begin
                if (start_load) begin
                    state_d  = ST_LOAD;
                    shadow_d = '0;
                    idx_d    = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d  = ST_RUN;
                    shadow_d = '0;
                    idx_d    = '0;
                end else if (load_valid) begin
                    shadow_d = shadow_upd;
                    idx_d    = idx_q + N_IN'(1);
                    if (idx_q == LAST_IDX) begin
                        active_d = shadow_upd;
                        state_d  = ST_RUN;
                        idx_d    = '0;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Evaluation is decided by the state at the sampling edge, so a request
    // sampled together with start_load still completes.
    always_comb begin
        x_valid_d = (state_q == ST_RUN) && in_valid;
        x_d       = x_valid_d ? active_q[in_vec] : x_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            active_q  <= TABLE_INIT;
            shadow_q  <= '0;
            idx_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = (state_q == ST_LOAD);
    assign load_ready = (state_q == ST_LOAD);

`ifdef CIRCUITO_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of x=1 results; clear wins over a simultaneous hit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (x_valid_q && x_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_circuito_programavel.sv
// Directed-vector bench for circuito_programavel (N_IN=4, CNT_W=2).
// Counter checks follow CIRCUITO_CNT_EN when it is defined for the build.
module tb_circuito_programavel;

    localparam int N_IN  = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_IN-1:0]  in_vec = '0;
    logic             in_valid = 1'b0;
    logic             x;
    logic             x_valid;
    logic             start_load = 1'b0;
    logic             load_bit = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic             abort = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] hit_cnt;
    logic             clr_cnt = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] cnt_hold;
    // Hand-derived from 16'h030B: ones at 0,1,3,8,9.
    logic [15:0] sweep_exp = 16'b0000_0011_0000_1011;

    circuito_programavel #(
        .N_IN      (N_IN),
        .TABLE_INIT(16'h030B),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .x         (x),
        .x_valid   (x_valid),
        .start_load(start_load),
        .load_bit  (load_bit),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .abort     (abort),
        .busy      (busy),
        .hit_cnt   (hit_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input logic [3:0] v, input logic exp_x, input string tag);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_xv"}, {31'd0, x_valid}, 32'd1);
        check({tag, "_x"}, {31'd0, x}, {31'd0, exp_x});
    endtask

    task automatic load_bits(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_bit   = b;
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values while rst_n is low
        #12;
        check("rst_x", {31'd0, x}, 32'd0);
        check("rst_xv", {31'd0, x_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd0);
        check("rst_cnt", {30'd0, hit_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sweep of the reset table
        for (int v = 0; v < 16; v++) begin
            eval(4'(v), sweep_exp[v], $sformatf("sweep%0d", v));
        end
        eval(4'd9, 1'b1, "pre_hold");
        tick();
        check("hold_xv", {31'd0, x_valid}, 32'd0);
        check("hold_x", {31'd0, x}, 32'd1);

        // Load 16'hFFFF with gaps, in_valid held high throughout
        in_vec     = 4'h0;
        in_valid   = 1'b1;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check("sl_busy", {31'd0, busy}, 32'd1);
        check("sl_ready", {31'd0, load_ready}, 32'd1);
        check("sl_inflight_xv", {31'd0, x_valid}, 32'd1);
        check("sl_inflight_x", {31'd0, x}, 32'd1);
        in_vec = 4'hF;
        tick();
        check("ld_gap0_xv", {31'd0, x_valid}, 32'd0);
        cnt_hold = hit_cnt;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_bit   = 1'b1;
            tick();
            load_valid = 1'b0;
            if (i < 15) begin
                check($sformatf("ld_bit%0d_busy", i), {31'd0, busy}, 32'd1);
                check($sformatf("ld_bit%0d_xv", i), {31'd0, x_valid}, 32'd0);
                tick();
                check($sformatf("ld_gap%0d_xv", i), {31'd0, x_valid}, 32'd0);
            end
        end
        check("ld_done_busy", {31'd0, busy}, 32'd0);
        check("ld_done_ready", {31'd0, load_ready}, 32'd0);
        check("ld_done_xv", {31'd0, x_valid}, 32'd0);
        check("ld_cnt_stable", {30'd0, hit_cnt}, {30'd0, cnt_hold});
        tick();
        in_valid = 1'b0;
        check("new_tbl_f_xv", {31'd0, x_valid}, 32'd1);
        check("new_tbl_f_x", {31'd0, x}, 32'd1);
        eval(4'd2, 1'b1, "new_tbl_2");
        eval(4'd4, 1'b1, "new_tbl_4");

        // Reset in the middle of a load
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        load_bits(7, 1'b0);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        eval(4'd2, 1'b0, "mid_rst_2");
        eval(4'd8, 1'b1, "mid_rst_8");
        eval(4'hF, 1'b0, "mid_rst_f");
        check("mid_rst_busy_run", {31'd0, busy}, 32'd0);

        // Abort after 10 zero bits
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        load_bits(10, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        eval(4'd0, 1'b1, "abort_0");
        eval(4'd1, 1'b1, "abort_1");
        eval(4'd2, 1'b0, "abort_2");

        // Abort coinciding with the final bit
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        load_bits(15, 1'b0);
        load_valid = 1'b1;
        load_bit   = 1'b0;
        abort      = 1'b1;
        tick();
        load_valid = 1'b0;
        abort      = 1'b0;
        check("abort_last_busy", {31'd0, busy}, 32'd0);
        eval(4'd0, 1'b1, "abort_last_0");
        eval(4'd3, 1'b1, "abort_last_3");

        // start_load held during LOAD must not restart the index
        start_load = 1'b1;
        tick();
        load_bits(15, 1'b0);
        start_load = 1'b0;
        load_bits(1, 1'b0);
        check("sl_ign_busy", {31'd0, busy}, 32'd0);
        eval(4'd0, 1'b0, "sl_ign_0");
        eval(4'd9, 1'b0, "sl_ign_9");

        // Hit counter: saturation and clear priority
        do_reset();
        in_vec   = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        tick();
`ifdef CIRCUITO_CNT_EN
        check("cnt_sat", {30'd0, hit_cnt}, 32'd3);
`else
        check("cnt_off_sat", {30'd0, hit_cnt}, 32'd0);
`endif
        in_valid = 1'b1;
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("cnt_clr", {30'd0, hit_cnt}, 32'd0);
        tick();
        in_valid = 1'b0;
`ifdef CIRCUITO_CNT_EN
        check("cnt_after_clr", {30'd0, hit_cnt}, 32'd1);
`else
        check("cnt_off_after", {30'd0, hit_cnt}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
